// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard receiver that maintains the active-low 8x8 LM80C key matrix.
// Optional Ctrl+Alt+Del request output is built when PS2_CTRL_ALT_DEL_EN is defined.
module ps2_keymatrix #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic       sys_clock,
    input  logic       RESET,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] KM [7:0],
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       reset_req
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) + 1 : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK, ST_SKIP
    } state_t;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_filt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          fall_q;
    logic [3:0]    bit_cnt_q;
    logic [8:0]    shift_q;
    logic [TW-1:0] to_cnt_q;
    logic          scan_valid_q;
    logic [7:0]    scan_code_q;
    state_t        state_q;
    logic [2:0]    skip_q;
    logic [7:0]    km_q [7:0];

    logic          lookup_ext, map_hit, is_make, is_break, clear_all;
    logic [2:0]    map_row, map_col;

    // Synchroniser plus level filter; the falling edge is registered so the
    // sampled data bit and the edge strobe come from the same cycle.
    always_ff @(posedge sys_clock or posedge RESET) begin
        if (RESET) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            fall_q     <= 1'b0;
            if (clk_sync_q[1] != clk_filt_q) begin
                if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                    clk_filt_q <= clk_sync_q[1];
                    flt_cnt_q  <= '0;
                    fall_q     <= clk_filt_q;
                end else begin
                    flt_cnt_q <= flt_cnt_q + FW'(1);
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    // Frame receiver: bit 0 start, 1..8 data, 9 parity (held in shift_q), 10 stop.
    always_ff @(posedge sys_clock or posedge RESET) begin
        if (RESET) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            to_cnt_q     <= '0;
            scan_valid_q <= 1'b0;
            scan_code_q  <= 8'h00;
        end else begin
            scan_valid_q <= 1'b0;
            if (fall_q) begin
                to_cnt_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    if (!dat_sync_q[1])
                        bit_cnt_q <= 4'd1;
                end else if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= 4'd0;
                    if (dat_sync_q[1] && (^shift_q)) begin
                        scan_valid_q <= 1'b1;
                        scan_code_q  <= shift_q[7:0];
                    end
                end else begin
                    shift_q   <= {dat_sync_q[1], shift_q[8:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    bit_cnt_q <= 4'd0;
                    to_cnt_q  <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign lookup_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BREAK);

    always_comb begin
        map_hit = 1'b1;
        map_row = 3'd0;
        map_col = 3'd0;
        case ({lookup_ext, scan_code_q})
            9'h01C: begin map_row = 3'd2; map_col = 3'd1; end
            9'h01B: begin map_row = 3'd2; map_col = 3'd2; end
            9'h023: begin map_row = 3'd2; map_col = 3'd3; end
            9'h02B: begin map_row = 3'd2; map_col = 3'd4; end
            9'h012: begin map_row = 3'd6; map_col = 3'd0; end
            9'h059: begin map_row = 3'd6; map_col = 3'd0; end
            9'h014: begin map_row = 3'd7; map_col = 3'd0; end
            9'h015: begin map_row = 3'd7; map_col = 3'd6; end
            9'h076: begin map_row = 3'd7; map_col = 3'd7; end
            9'h05A: begin map_row = 3'd1; map_col = 3'd7; end
            9'h01D: begin map_row = 3'd1; map_col = 3'd1; end
            9'h024: begin map_row = 3'd1; map_col = 3'd6; end
            9'h029: begin map_row = 3'd0; map_col = 3'd4; end
            9'h016: begin map_row = 3'd0; map_col = 3'd0; end
            9'h01E: begin map_row = 3'd0; map_col = 3'd3; end
            9'h066: begin map_row = 3'd3; map_col = 3'd7; end
            9'h114: begin map_row = 3'd7; map_col = 3'd0; end
            9'h15A: begin map_row = 3'd1; map_col = 3'd7; end
            9'h16B: begin map_row = 3'd4; map_col = 3'd3; end
            9'h174: begin map_row = 3'd4; map_col = 3'd2; end
            9'h175: begin map_row = 3'd4; map_col = 3'd4; end
            9'h172: begin map_row = 3'd4; map_col = 3'd5; end
            9'h171: begin map_row = 3'd3; map_col = 3'd6; end
            default: map_hit = 1'b0;
        endcase
    end

    always_comb begin
        is_make   = 1'b0;
        is_break  = 1'b0;
        clear_all = 1'b0;
        if (scan_valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    case (scan_code_q)
                        8'hF0, 8'hE0, 8'hE1,
                        8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                        8'h00, 8'hFF:               clear_all = 1'b1;
                        default:                    is_make   = 1'b1;
                    endcase
                end
                ST_BREAK:     is_break = 1'b1;
                ST_EXT: begin
                    // E0 12 / E0 59 are the fake shifts sent around grey keys.
                    if (scan_code_q != 8'hF0 && scan_code_q != 8'h12 && scan_code_q != 8'h59)
                        is_make = 1'b1;
                end
                ST_EXT_BREAK: is_break = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clock or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
            for (int r = 0; r < 8; r++)
                km_q[r] <= 8'hFF;
        end else begin
            if (clear_all) begin
                for (int r = 0; r < 8; r++)
                    km_q[r] <= 8'hFF;
            end else if ((is_make || is_break) && map_hit) begin
                km_q[map_row][map_col] <= is_break;
            end
            if (scan_valid_q) begin
                case (state_q)
                    ST_IDLE: begin
                        case (scan_code_q)
                            8'hF0: state_q <= ST_BREAK;
                            8'hE0: state_q <= ST_EXT;
                            8'hE1: begin
                                state_q <= ST_SKIP;
                                skip_q  <= 3'd7;
                            end
                            default: ;
                        endcase
                    end
                    ST_EXT:  state_q <= (scan_code_q == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
                    ST_SKIP: begin
                        skip_q <= skip_q - 3'd1;
                        if (skip_q == 3'd1)
                            state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef PS2_CTRL_ALT_DEL_EN
    logic ctrl_q, alt_q, del_q, reset_req_q;

    always_ff @(posedge sys_clock or posedge RESET) begin
        if (RESET) begin
            ctrl_q      <= 1'b0;
            alt_q       <= 1'b0;
            del_q       <= 1'b0;
            reset_req_q <= 1'b0;
        end else begin
            if (clear_all) begin
                ctrl_q <= 1'b0;
                alt_q  <= 1'b0;
                del_q  <= 1'b0;
            end else if (is_make || is_break) begin
                if (scan_code_q == 8'h14)
                    ctrl_q <= is_make;
                if (scan_code_q == 8'h11)
                    alt_q <= is_make;
                if (lookup_ext && scan_code_q == 8'h71)
                    del_q <= is_make;
            end
            reset_req_q <= ctrl_q & alt_q & del_q;
        end
    end

    assign reset_req = reset_req_q;
`else
    assign reset_req = 1'b0;
`endif

    assign KM         = km_q;
    assign scan_valid = scan_valid_q;
    assign scan_code  = scan_code_q;

endmodule
